multicyc_mcu_hs: RTL and testbench
==================================

MULTICYC_MCU_HS -- requirements
Module: multicyc_mcu_hs

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum consecutive mem_ready-low cycles allowed in one memory state; 0 disables the timeout.
REQ-002 Parameter TRAP_ILLEGAL, default 1: 1 sends unknown opcodes to FAULT; 0 sends them back to FETCH.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 opcode  in  6  instr[31:26] from the IR; stable from DECODE until the next FETCH.
REQ-007 mem_ready  in  1  memory completes the current request this cycle.
REQ-008 mem_req  out  1  memory request valid.
REQ-009 mem_we  out  1  request is a write.
REQ-010 mem_addr_sel  out  1  0=PC, 1=ALUout.
REQ-011 ir_we  out  1  IR load enable.
REQ-012 pc_we  out  1  unconditional PC write.
REQ-013 alu_srca_sel  out  1  0=PC, 1=Rs.
REQ-014 alu_srcb_sel  out  2  00=Rt, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
REQ-015 aluop  out  4  ALUops package encoding.
REQ-016 reg_we  out  1  register-file write enable.
REQ-017 wreg_dst_sel  out  2  00=Rt, 01=Rd, 10=$31.
REQ-018 wrbck_data_sel  out  2  00=ALUout, 01=memory data, 10=PC.
REQ-019 nxt_pc_sel  out  2  00=PC+4, 01=branch target, 10=jump target.
REQ-020 is_branch  out  1  datapath writes PC when the zero-flag condition holds.
REQ-021 branch_ne  out  1  condition is zero==0 (BNE); otherwise zero==1.
REQ-022 fault  out  1  sticky error flag.
REQ-023 state  out  4  current state encoding.
REQ-024 retired  out  CNT_W  count of completed instructions.

Function
REQ-025 State encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWR=4, MEMWB=5, RREXEC=6, RRWB=7, RIEXEC=8, RIWB=9, BRANCH=10, JUMP=11, FAULT=15; all other codes go to FETCH.
REQ-026 Every control output is 0 in every state unless listed below; outputs are a pure function of state, opcode and mem_ready.
REQ-027 FETCH: mem_req=1, mem_addr_sel=0, srca=0, srcb=01, aluop=ADD, nxt_pc_sel=00; when mem_ready=1, ir_we=1 and pc_we=1 and the next state is DECODE; otherwise stay in FETCH.
REQ-028 DECODE: srca=0, srcb=11, aluop=ADD. Next state by opcode: LW(0x23)/SW(0x2B)->MEMADDR; 0x00->RREXEC; BEQ(0x04)/BNE(0x05)->BRANCH; J(0x02)/JAL(0x03)->JUMP; ADDI(0x08), ADDIU(0x09), ANDI(0x0C), ORI(0x0D), XORI(0x0E)->RIEXEC; any other opcode->FAULT if TRAP_ILLEGAL else FETCH.
REQ-029 MEMADDR: srca=1, srcb=10, aluop=ADD; next state MEMRD if LW, else MEMWR.
REQ-030 MEMRD: mem_req=1, mem_addr_sel=1; mem_ready=1 -> MEMWB. MEMWR: additionally mem_we=1; mem_ready=1 -> FETCH.
REQ-031 MEMWB: reg_we=1, wreg_dst_sel=00, wrbck_data_sel=01; next state FETCH.
REQ-032 RREXEC: srca=1, srcb=00, aluop=ALUop_RR; next RRWB. RRWB: reg_we=1, wreg_dst_sel=01, wrbck_data_sel=00; next FETCH.
REQ-033 RIEXEC: srca=1, srcb=10, aluop ADD/ADDU/AND/OR/XOR for ADDI/ADDIU/ANDI/ORI/XORI; next RIWB. RIWB: reg_we=1, wreg_dst_sel=00, wrbck_data_sel=00; next FETCH.
REQ-034 BRANCH: srca=1, srcb=00, aluop=SUB, nxt_pc_sel=01, is_branch=1, branch_ne=(opcode==BNE); next FETCH.
REQ-035 JUMP: nxt_pc_sel=10, pc_we=1; for JAL also reg_we=1, wreg_dst_sel=10, wrbck_data_sel=10 (PC already holds PC+4); next FETCH.
REQ-036 A wait counter clears on every state change and increments on each cycle a memory state (FETCH, MEMRD, MEMWR) sees mem_ready=0; with TIMEOUT>0, the TIMEOUT-th consecutive low cycle moves the FSM to FAULT on the next edge instead of staying.
REQ-037 mem_req, mem_we and mem_addr_sel stay constant while waiting; mem_ready is ignored outside memory states.
REQ-038 FAULT: fault=1, all other control outputs 0; the FSM stays in FAULT until reset.
REQ-039 retired increments by 1 on each transition into FETCH from MEMWR, MEMWB, RRWB, RIWB, BRANCH or JUMP; it wraps modulo 2^CNT_W; illegal-opcode returns do not count.

Reset
REQ-040 reset=1 at a clock edge forces state=FETCH, retired=0, fault=0 and wait counter=0, overriding any transition including mid-wait; outputs take FETCH values on the following cycle.

Verification
REQ-041 R-type, mem_ready=1 constant -> states 0,1,6,7,0; reg_we=1 only in RRWB with wreg_dst_sel=01; retired 0->1.
REQ-042 LW with mem_ready low for 3 cycles in MEMRD -> state 3 held for 4 cycles, mem_req=1 and mem_addr_sel=1 throughout, then MEMWB with wrbck_data_sel=01; fault stays 0.
REQ-043 TIMEOUT=16, mem_ready=0 in FETCH -> state=15 and fault=1 after 16 wait cycles and held; reset -> state=0, fault=0.
REQ-044 JAL (0x03) -> JUMP with pc_we=1, nxt_pc_sel=10, reg_we=1, wreg_dst_sel=10, wrbck_data_sel=10; BNE (0x05) -> BRANCH with branch_ne=1; BEQ -> branch_ne=0.
REQ-045 opcode 0x3F -> FAULT when TRAP_ILLEGAL=1; when TRAP_ILLEGAL=0 -> FETCH with retired unchanged.
REQ-046 reset asserted during a MEMWR wait -> next state 0, mem_we=0, retired=0.

Source files
------------

// File: rtl/multicyc_mcu_hs.sv
// -----------------------------------------------------------------------------
// multicyc_mcu_hs -- main control FSM for a multicycle MIPS-style core that
// talks to memory through a ready handshake.
//
// Parameters
//   TIMEOUT      max consecutive mem_ready-low cycles in one memory state
//                (0 = never time out)
//   TRAP_ILLEGAL 1: unknown opcodes go to FAULT, 0: they go back to FETCH
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   opcode            instr[31:26] from the IR
//   mem_ready         memory finishes the current request this cycle
//   mem_req/mem_we/mem_addr_sel    memory request controls
//   ir_we/pc_we                    IR and unconditional PC write enables
//   alu_srca_sel/alu_srcb_sel/aluop ALU operand and operation selects
//   reg_we/wreg_dst_sel/wrbck_data_sel  register-file write controls
//   nxt_pc_sel/is_branch/branch_ne      next-PC controls
//   fault             error flag, held until reset
//   state             current state encoding
//   retired           completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicyc_mcu_hs #(
    parameter int TIMEOUT      = 16,
    parameter int TRAP_ILLEGAL = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             alu_srca_sel,
    output logic [1:0]       alu_srcb_sel,
    output logic [3:0]       aluop,
    output logic             reg_we,
    output logic [1:0]       wreg_dst_sel,
    output logic [1:0]       wrbck_data_sel,
    output logic [1:0]       nxt_pc_sel,
    output logic             is_branch,
    output logic             branch_ne,
    output logic             fault,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    // ALU operation encoding shared with the datapath
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_ADDU = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_RR   = 4'hF; // datapath decodes funct field

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWR   = 4'd4,
        S_MEMWB   = 4'd5,
        S_RREXEC  = 4'd6,
        S_RRWB    = 4'd7,
        S_RIEXEC  = 4'd8,
        S_RIWB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_FAULT   = 4'd15
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic is_mem_state;
    logic timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr_sel   = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        alu_srca_sel   = 1'b0;
        alu_srcb_sel   = 2'b00;
        aluop          = 4'h0;
        reg_we         = 1'b0;
        wreg_dst_sel   = 2'b00;
        wrbck_data_sel = 2'b00;
        nxt_pc_sel     = 2'b00;
        is_branch      = 1'b0;
        branch_ne      = 1'b0;
        fault          = 1'b0;

        is_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);
        // This low cycle is the TIMEOUT-th in a row: leave for FAULT next edge
        timed_out = (TIMEOUT != 0) && is_mem_state && !mem_ready &&
                    (wait_q == WAIT_W'(TIMEOUT - 1));

        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_srcb_sel = 2'b01;
                aluop        = ALU_ADD;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_srcb_sel = 2'b11;
                aluop        = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADDR;
                    OP_RTYPE:       state_d = S_RREXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI:
                                    state_d = S_RIEXEC;
                    default:        state_d = (TRAP_ILLEGAL != 0) ? S_FAULT : S_FETCH;
                endcase
            end
            S_MEMADDR: begin
                alu_srca_sel = 1'b1;
                alu_srcb_sel = 2'b10;
                aluop        = ALU_ADD;
                state_d      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                reg_we         = 1'b1;
                wrbck_data_sel = 2'b01;
                state_d        = S_FETCH;
            end
            S_RREXEC: begin
                alu_srca_sel = 1'b1;
                aluop        = ALU_RR;
                state_d      = S_RRWB;
            end
            S_RRWB: begin
                reg_we       = 1'b1;
                wreg_dst_sel = 2'b01;
                state_d      = S_FETCH;
            end
            S_RIEXEC: begin
                alu_srca_sel = 1'b1;
                alu_srcb_sel = 2'b10;
                case (opcode)
                    OP_ADDIU: aluop = ALU_ADDU;
                    OP_ANDI:  aluop = ALU_AND;
                    OP_ORI:   aluop = ALU_OR;
                    OP_XORI:  aluop = ALU_XOR;
                    default:  aluop = ALU_ADD;
                endcase
                state_d = S_RIWB;
            end
            S_RIWB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_srca_sel = 1'b1;
                aluop        = ALU_SUB;
                nxt_pc_sel   = 2'b01;
                is_branch    = 1'b1;
                branch_ne    = (opcode == OP_BNE);
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                nxt_pc_sel = 2'b10;
                pc_we      = 1'b1;
                // PC already advanced in FETCH, so the link value is PC itself
                if (opcode == OP_JAL) begin
                    reg_we         = 1'b1;
                    wreg_dst_sel   = 2'b10;
                    wrbck_data_sel = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_FAULT: begin
                fault   = 1'b1;
                state_d = S_FAULT;
            end
            default: state_d = S_FETCH;
        endcase

        if (timed_out) state_d = S_FAULT;
    end

    // Wait counter restarts on any state change
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (is_mem_state && !mem_ready)
            wait_d = wait_q + WAIT_W'(1);
    end

    // Only completions of real instructions count; illegal returns from DECODE do not
    always_comb begin
        retired_d = retired_q;
        if (state_d == S_FETCH &&
            (state_q == S_MEMWR || state_q == S_MEMWB || state_q == S_RRWB ||
             state_q == S_RIWB  || state_q == S_BRANCH || state_q == S_JUMP))
            retired_d = retired_q + CNT_W'(1);
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicyc_mcu_hs.sv
module tb_multicyc_mcu_hs;

    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_RR  = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_srca_sel;
    logic [1:0]  alu_srcb_sel;
    logic [3:0]  aluop;
    logic        reg_we;
    logic [1:0]  wreg_dst_sel, wrbck_data_sel, nxt_pc_sel;
    logic        is_branch, branch_ne, fault;
    logic [3:0]  state;
    logic [15:0] retired;

    // Second instance with illegal-opcode trapping disabled, same inputs
    logic        mem_req2, mem_we2, mem_addr_sel2, ir_we2, pc_we2, alu_srca_sel2;
    logic [1:0]  alu_srcb_sel2;
    logic [3:0]  aluop2;
    logic        reg_we2;
    logic [1:0]  wreg_dst_sel2, wrbck_data_sel2, nxt_pc_sel2;
    logic        is_branch2, branch_ne2, fault2;
    logic [3:0]  state2;
    logic [15:0] retired2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicyc_mcu_hs #(.TIMEOUT(16), .TRAP_ILLEGAL(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .alu_srca_sel(alu_srca_sel),
        .alu_srcb_sel(alu_srcb_sel), .aluop(aluop), .reg_we(reg_we),
        .wreg_dst_sel(wreg_dst_sel), .wrbck_data_sel(wrbck_data_sel),
        .nxt_pc_sel(nxt_pc_sel), .is_branch(is_branch), .branch_ne(branch_ne),
        .fault(fault), .state(state), .retired(retired)
    );

    multicyc_mcu_hs #(.TIMEOUT(16), .TRAP_ILLEGAL(0), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr_sel(mem_addr_sel2),
        .ir_we(ir_we2), .pc_we(pc_we2), .alu_srca_sel(alu_srca_sel2),
        .alu_srcb_sel(alu_srcb_sel2), .aluop(aluop2), .reg_we(reg_we2),
        .wreg_dst_sel(wreg_dst_sel2), .wrbck_data_sel(wrbck_data_sel2),
        .nxt_pc_sel(nxt_pc_sel2), .is_branch(is_branch2), .branch_ne(branch_ne2),
        .fault(fault2), .state(state2), .retired(retired2)
    );

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        opcode = 6'h00; mem_ready = 1'b0;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        #1;
        vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", state); end
        vectors++; if (retired !== 16'd0) begin miscompares++; $display("FAIL rst_retired got %0d want 0", retired); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %0b want 0", fault); end
        vectors++; if ({mem_req, mem_addr_sel, ir_we, pc_we} !== 4'b1000) begin miscompares++; $display("FAIL rst_fetch_wait req/asel/irwe/pcwe got %b want 1000", {mem_req, mem_addr_sel, ir_we, pc_we}); end
    endtask

    task automatic test_rtype();
        opcode = 6'h00; mem_ready = 1'b1; #1;
        vectors++; if ({state, ir_we, pc_we, alu_srcb_sel, aluop} !== {4'd0, 1'b1, 1'b1, 2'b01, ALU_ADD}) begin miscompares++; $display("FAIL rt_fetch got st=%0d ir=%b pc=%b sb=%b op=%h", state, ir_we, pc_we, alu_srcb_sel, aluop); end
        tick();
        vectors++; if ({state, alu_srca_sel, alu_srcb_sel, aluop, reg_we} !== {4'd1, 1'b0, 2'b11, ALU_ADD, 1'b0}) begin miscompares++; $display("FAIL rt_decode got st=%0d sa=%b sb=%b op=%h we=%b", state, alu_srca_sel, alu_srcb_sel, aluop, reg_we); end
        tick();
        vectors++; if ({state, alu_srca_sel, alu_srcb_sel, aluop, reg_we} !== {4'd6, 1'b1, 2'b00, ALU_RR, 1'b0}) begin miscompares++; $display("FAIL rt_exec got st=%0d sa=%b sb=%b op=%h we=%b", state, alu_srca_sel, alu_srcb_sel, aluop, reg_we); end
        tick();
        vectors++; if ({state, reg_we, wreg_dst_sel, wrbck_data_sel} !== {4'd7, 1'b1, 2'b01, 2'b00}) begin miscompares++; $display("FAIL rt_wb got st=%0d we=%b dst=%b wb=%b", state, reg_we, wreg_dst_sel, wrbck_data_sel); end
        tick();
        vectors++; if ({state, retired} !== {4'd0, 16'd1}) begin miscompares++; $display("FAIL rt_retire got st=%0d ret=%0d want st=0 ret=1", state, retired); end
    endtask

    task automatic test_lw_wait();
        opcode = 6'h23; mem_ready = 1'b1;
        tick(); tick();
        vectors++; if ({state, alu_srca_sel, alu_srcb_sel, aluop} !== {4'd2, 1'b1, 2'b10, ALU_ADD}) begin miscompares++; $display("FAIL lw_memaddr got st=%0d sa=%b sb=%b op=%h", state, alu_srca_sel, alu_srcb_sel, aluop); end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            vectors++; if ({state, mem_req, mem_addr_sel, mem_we, fault} !== {4'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin miscompares++; $display("FAIL lw_memrd_c%0d got st=%0d req=%b asel=%b we=%b flt=%b", i, state, mem_req, mem_addr_sel, mem_we, fault); end
            tick();
        end
        vectors++; if ({state, reg_we, wreg_dst_sel, wrbck_data_sel, fault} !== {4'd5, 1'b1, 2'b00, 2'b01, 1'b0}) begin miscompares++; $display("FAIL lw_memwb got st=%0d we=%b dst=%b wb=%b flt=%b", state, reg_we, wreg_dst_sel, wrbck_data_sel, fault); end
        tick();
        vectors++; if ({state, retired} !== {4'd0, 16'd2}) begin miscompares++; $display("FAIL lw_retire got st=%0d ret=%0d want st=0 ret=2", state, retired); end
    endtask

    task automatic test_jump_branch();
        mem_ready = 1'b1;
        opcode = 6'h03; tick(); tick();
        vectors++; if ({state, pc_we, nxt_pc_sel, reg_we, wreg_dst_sel, wrbck_data_sel} !== {4'd11, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10}) begin miscompares++; $display("FAIL jal got st=%0d pcwe=%b npc=%b we=%b dst=%b wb=%b", state, pc_we, nxt_pc_sel, reg_we, wreg_dst_sel, wrbck_data_sel); end
        tick();
        opcode = 6'h05; tick(); tick();
        vectors++; if ({state, is_branch, branch_ne, nxt_pc_sel, aluop, alu_srca_sel} !== {4'd10, 1'b1, 1'b1, 2'b01, ALU_SUB, 1'b1}) begin miscompares++; $display("FAIL bne got st=%0d br=%b ne=%b npc=%b op=%h sa=%b", state, is_branch, branch_ne, nxt_pc_sel, aluop, alu_srca_sel); end
        tick();
        opcode = 6'h04; tick(); tick();
        vectors++; if ({state, is_branch, branch_ne} !== {4'd10, 1'b1, 1'b0}) begin miscompares++; $display("FAIL beq got st=%0d br=%b ne=%b", state, is_branch, branch_ne); end
        tick();
        vectors++; if ({state, retired} !== {4'd0, 16'd5}) begin miscompares++; $display("FAIL jb_retire got st=%0d ret=%0d want st=0 ret=5", state, retired); end
    endtask

    task automatic test_itype();
        mem_ready = 1'b1; opcode = 6'h0D; tick(); tick();
        vectors++; if ({state, alu_srca_sel, alu_srcb_sel, aluop} !== {4'd8, 1'b1, 2'b10, ALU_OR}) begin miscompares++; $display("FAIL ori_exec got st=%0d sa=%b sb=%b op=%h", state, alu_srca_sel, alu_srcb_sel, aluop); end
        tick();
        vectors++; if ({state, reg_we, wreg_dst_sel, wrbck_data_sel} !== {4'd9, 1'b1, 2'b00, 2'b00}) begin miscompares++; $display("FAIL ori_wb got st=%0d we=%b dst=%b wb=%b", state, reg_we, wreg_dst_sel, wrbck_data_sel); end
        tick();
        vectors++; if (retired !== 16'd6) begin miscompares++; $display("FAIL ori_retire got %0d want 6", retired); end
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1; opcode = 6'h3F; tick(); tick();
        vectors++; if ({state, fault, mem_req} !== {4'd15, 1'b1, 1'b0}) begin miscompares++; $display("FAIL ill_trap got st=%0d flt=%b req=%b want 15/1/0", state, fault, mem_req); end
        vectors++; if ({state2, fault2, retired2} !== {4'd0, 1'b0, 16'd6}) begin miscompares++; $display("FAIL ill_notrap got st=%0d flt=%b ret=%0d want 0/0/6", state2, fault2, retired2); end
        opcode = 6'h00; tick(); tick(); tick();
        vectors++; if ({state, fault} !== {4'd15, 1'b1}) begin miscompares++; $display("FAIL ill_hold got st=%0d flt=%b want 15/1", state, fault); end
        do_reset();
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0; opcode = 6'h00;
        for (int i = 0; i < 15; i++) tick();
        vectors++; if ({state, fault} !== {4'd0, 1'b0}) begin miscompares++; $display("FAIL to_before got st=%0d flt=%b want 0/0", state, fault); end
        tick();
        vectors++; if ({state, fault} !== {4'd15, 1'b1}) begin miscompares++; $display("FAIL to_fault got st=%0d flt=%b want 15/1", state, fault); end
        mem_ready = 1'b1; tick(); tick();
        vectors++; if ({state, fault} !== {4'd15, 1'b1}) begin miscompares++; $display("FAIL to_hold got st=%0d flt=%b want 15/1", state, fault); end
        do_reset(); #1;
        vectors++; if ({state, fault} !== {4'd0, 1'b0}) begin miscompares++; $display("FAIL to_reset got st=%0d flt=%b want 0/0", state, fault); end
    endtask

    task automatic test_reset_mid_wait();
        mem_ready = 1'b1; opcode = 6'h00;
        tick(); tick(); tick(); tick();
        vectors++; if (retired !== 16'd1) begin miscompares++; $display("FAIL rmw_pre_ret got %0d want 1", retired); end
        opcode = 6'h2B; tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        vectors++; if ({state, mem_req, mem_we, mem_addr_sel} !== {4'd4, 1'b1, 1'b1, 1'b1}) begin miscompares++; $display("FAIL sw_memwr got st=%0d req=%b we=%b asel=%b", state, mem_req, mem_we, mem_addr_sel); end
        tick(); tick();
        vectors++; if ({state, mem_we} !== {4'd4, 1'b1}) begin miscompares++; $display("FAIL sw_wait got st=%0d we=%b want 4/1", state, mem_we); end
        mem_ready = 1'b1; reset = 1'b1; tick(); reset = 1'b0; mem_ready = 1'b0; #1;
        vectors++; if ({state, mem_we, retired} !== {4'd0, 1'b0, 16'd0}) begin miscompares++; $display("FAIL rmw_reset got st=%0d we=%b ret=%0d want 0/0/0", state, mem_we, retired); end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_jump_branch();
        test_itype();
        test_illegal();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
